// File: rtl/reg_mem_arbiter.sv
// rtl/reg_mem_arbiter.sv - two-client round-robin arbiter and sequencer for reg_mem
//
// Two clients each issue read/write requests over a valid/ready handshake.
// Requests are granted round-robin and executed one at a time against a
// single-port memory. Each request gets a one-cycle response pulse back.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   req{0,1}_valid/_ready           request handshake per client
//   req{0,1}_we/_addr/_wdata        request fields, sampled at handshake
//   rsp{0,1}_valid/_rdata           response pulse and read data (0 on write ack)
//   mem_addr/mem_data_in/mem_wen    drive the memory pins
//   mem_data_out                    read data from the memory
//   busy                            high whenever an operation is in flight
module reg_mem_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_we,
   input  logic [ADDR_BITS-1:0]  req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_we,
   input  logic [ADDR_BITS-1:0]  req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic [ADDR_BITS-1:0]  mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  mem_wen,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t state;
   logic   last_grant;
   logic   lat_we;
   logic   lat_id;
   logic   grant;
   logic   handshake;

   // Lone requester wins; on a tie the client that did not go last wins.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid)
         grant = ~last_grant;
      else if (req1_valid)
         grant = 1'b1;
   end

   // Ready is gated by rst so neither client sees a handshake while held in reset.
   assign req0_ready = !rst && (state == IDLE) && req0_valid && !grant;
   assign req1_ready = !rst && (state == IDLE) && req1_valid &&  grant;
   assign handshake  = req0_ready || req1_ready;

   // Decoded from state so that reset removes the write enable immediately.
   assign mem_wen = (state == ACCESS) && lat_we;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         lat_we      <= 1'b0;
         lat_id      <= 1'b0;
         mem_addr    <= '0;
         mem_data_in <= '0;
         rsp0_valid  <= 1'b0;
         rsp0_rdata  <= '0;
         rsp1_valid  <= 1'b0;
         rsp1_rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               // mem_addr/mem_data_in only change here, so they hold steady while idle.
               if (handshake) begin
                  lat_id      <= grant;
                  last_grant  <= grant;
                  lat_we      <= grant ? req1_we    : req0_we;
                  mem_addr    <= grant ? req1_addr  : req0_addr;
                  mem_data_in <= grant ? req1_wdata : req0_wdata;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               if (lat_we) begin
                  // Write commits on this edge; acknowledge with zero data.
                  if (lat_id) begin
                     rsp1_valid <= 1'b1;
                     rsp1_rdata <= '0;
                  end else begin
                     rsp0_valid <= 1'b1;
                     rsp0_rdata <= '0;
                  end
                  state <= RESP;
               end else begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               // One cycle of address hold covers both combinational and
               // single-cycle registered memory reads.
               if (lat_id) begin
                  rsp1_valid <= 1'b1;
                  rsp1_rdata <= mem_data_out;
               end else begin
                  rsp0_valid <= 1'b1;
                  rsp0_rdata <= mem_data_out;
               end
               state <= RESP;
            end
            RESP: begin
               rsp0_valid <= 1'b0;
               rsp0_rdata <= '0;
               rsp1_valid <= 1'b0;
               rsp1_rdata <= '0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_mem_arbiter.sv
// tb/tb_reg_mem_arbiter.sv - directed self-checking bench for reg_mem_arbiter
module tb_reg_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready, req0_we;
   logic [4:0] req0_addr;
   logic [7:0] req0_wdata;
   logic       rsp0_valid;
   logic [7:0] rsp0_rdata;
   logic       req1_valid, req1_ready, req1_we;
   logic [4:0] req1_addr;
   logic [7:0] req1_wdata;
   logic       rsp1_valid;
   logic [7:0] rsp1_rdata;
   logic [4:0] mem_addr;
   logic [7:0] mem_data_in;
   logic       mem_wen;
   logic [7:0] mem_data_out;
   logic       busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_mem_arbiter #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wen(mem_wen),
      .mem_data_out(mem_data_out), .busy(busy)
   );

   // Memory model: synchronous write, combinational read.
   logic [7:0] mem [32];
   always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_data_in;
   assign mem_data_out = mem[mem_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sample point: 1 time unit after the rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input int c, input logic we, input logic [4:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd);
      int   n;
      logic rdy, rv, other;
      logic [7:0] rd;
      if (c == 0) begin
         req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d;
      end
      #1;
      n   = 0;
      rdy = (c == 0) ? req0_ready : req1_ready;
      while (!rdy && n < 20) begin
         @(posedge clk); #2;
         n++;
         rdy = (c == 0) ? req0_ready : req1_ready;
      end
      check("handshake", rdy, 1'b1);
      next_cycle();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      n = 1;
      if (we) check("wen_access", mem_wen, 1'b1);
      rv = (c == 0) ? rsp0_valid : rsp1_valid;
      while (!rv && n < 10) begin
         next_cycle();
         n++;
         if (we && n > 1) check("wen_once", mem_wen, 1'b0);
         rv = (c == 0) ? rsp0_valid : rsp1_valid;
      end
      rd    = (c == 0) ? rsp0_rdata : rsp1_rdata;
      other = (c == 0) ? rsp1_valid : rsp0_valid;
      check("rsp_latency", n, we ? 2 : 3);
      check("rsp_rdata", rd, exp_rd);
      check("other_rsp", other, 1'b0);
      next_cycle();
      rd = (c == 0) ? rsp0_rdata : rsp1_rdata;
      check("rsp_clear", {rsp0_valid, rsp1_valid, rd}, 10'h0);
   endtask

   initial begin
      int   hcount, dbl;
      int   order [4];
      logic p0, p1;
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 5'd3; req0_wdata = 8'h00;
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 5'd4; req1_wdata = 8'h00;

      // 1. Reset with both clients requesting.
      rst = 1'b1;
      repeat (2) next_cycle();
      check("rst_ready", {req0_ready, req1_ready}, 2'b00);
      check("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata}, 18'h0);
      check("rst_mem", {mem_wen, mem_addr, mem_data_in, busy}, 15'h0);
      rst = 1'b0;
      #1;
      check("rel_ready", {req0_ready, req1_ready}, 2'b10);
      req0_valid = 1'b0; req1_valid = 1'b0;
      next_cycle();
      check("idle_busy", busy, 1'b0);

      // 2/3. Write then read back from client 0.
      do_op(0, 1'b1, 5'd12, 8'h0A, 8'h00);
      check("mem12", mem[12], 8'h0A);
      do_op(0, 1'b0, 5'd12, 8'h00, 8'h0A);
      check("addr_hold", mem_addr, 5'd12);

      // 4. Both valid continuously from reset: expect c0,c1,c0,c1.
      rst = 1'b1; next_cycle(); rst = 1'b0;
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 5'd12;
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 5'd12;
      hcount = 0; dbl = 0; p0 = 1'b0; p1 = 1'b0;
      for (int cyc = 0; cyc < 40 && hcount < 4; cyc++) begin
         #1;
         if (req0_ready && req1_ready) dbl++;
         if ((req0_ready && p0) || (req1_ready && p1)) dbl++;
         if (req0_ready) begin order[hcount] = 0; hcount++; end
         else if (req1_ready) begin order[hcount] = 1; hcount++; end
         p0 = req0_ready; p1 = req1_ready;
         @(posedge clk);
      end
      #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("rr_count", hcount, 4);
      check("rr_pulse", dbl, 0);
      check("rr_g0", order[0], 0);
      check("rr_g1", order[1], 1);
      check("rr_g2", order[2], 0);
      check("rr_g3", order[3], 1);
      repeat (5) next_cycle();

      // 5. Client 1 fills memory, client 0 reads it back.
      for (int i = 0; i < 32; i++) do_op(1, 1'b1, i[4:0], 8'(i + 10), 8'h00);
      for (int i = 0; i < 32; i++) do_op(0, 1'b0, i[4:0], 8'h00, 8'(i + 10));

      // 6. Reset during CAPTURE drops the read.
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 5'd7;
      #1;
      check("r6_ready", req0_ready, 1'b1);
      next_cycle();
      req0_valid = 1'b0;
      next_cycle();
      rst = 1'b1;
      #1;
      check("r6_rst_out", {mem_wen, busy, rsp0_valid, rsp1_valid}, 4'b0000);
      next_cycle();
      rst = 1'b0;
      p0 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         if (rsp0_valid || rsp1_valid || mem_wen) p0 = 1'b1;
      end
      check("r6_no_rsp", p0, 1'b0);
      do_op(0, 1'b0, 5'd7, 8'h00, 8'd17);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
